cpu_run_control: RTL and testbench

Execution-rate controller that drives the `enable` input of the CPU core. It is the stage directly upstream of the CPU.
- Turns raw run and step buttons, a turbo switch and an 8-bit breakpoint address into single-cycle `enable` strobes.
- Watches the CPU's `instruction_pointer` to stop before the breakpoint instruction executes.
- Counts the instructions it has released.

---
 rtl/cpu_run_control.sv | 129 ++++++++++++
 tb/tb_cpu_run_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_control.sv
// rtl/cpu_run_control.sv - execution-rate controller producing single-cycle CPU enable strobes
module cpu_run_control #(
    parameter int SLOW_DIV = 50_000_000,
    parameter int FAST_DIV = 5_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        turbo,
    input  logic        bp_enable,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  instruction_pointer,
    output logic        enable,
    output logic [1:0]  state,
    output logic [15:0] instr_count
);
    localparam int CW = $clog2(SLOW_DIV) + 1;
    localparam logic [CW-1:0] SLOW_LIM = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] FAST_LIM = CW'(FAST_DIV - 1);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic [2:0]    run_sync;
    logic [2:0]    step_sync;
    logic          run_p;
    logic          step_p;
    logic          tc;
    logic          bp_hit;
    logic          skip;
    logic          skip_set;
    logic          enable_next;
    logic [CW-1:0] div_cnt;

    // Bits [1:0] synchronise the raw button, bit [2] is the edge-detector history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_sync  <= '0;
            step_sync <= '0;
        end else begin
            run_sync  <= {run_sync[1:0], btn_run};
            step_sync <= {step_sync[1:0], btn_step};
        end
    end

    assign run_p  = run_sync[1] & ~run_sync[2];
    assign step_p = step_sync[1] & ~step_sync[2];

    // >= rather than == so a turbo switch past the new limit fires immediately.
    assign tc     = div_cnt >= (turbo ? FAST_LIM : SLOW_LIM);
    assign bp_hit = bp_enable && (instruction_pointer == bp_addr) && !skip;

    always_comb begin
        next_state  = cur_state;
        enable_next = 1'b0;
        skip_set    = 1'b0;
        case (cur_state)
            HALT: begin
                if (run_p) begin
                    next_state = RUN;
                end else if (step_p) begin
                    next_state  = STEP;
                    enable_next = 1'b1;
                end
            end
            RUN: begin
                if (run_p) begin
                    next_state = HALT;
                end else if (tc && bp_hit) begin
                    next_state = BREAK;
                end else if (tc) begin
                    enable_next = 1'b1;
                end
            end
            STEP: begin
                next_state = HALT;
            end
            BREAK: begin
                if (run_p) begin
                    next_state = RUN;
                    skip_set   = 1'b1;
                end else if (step_p) begin
                    next_state  = STEP;
                    enable_next = 1'b1;
                end
            end
            default: begin
                next_state = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state   <= HALT;
            enable      <= 1'b0;
            instr_count <= '0;
            div_cnt     <= '0;
            skip        <= 1'b0;
        end else begin
            cur_state <= next_state;
            enable    <= enable_next;
            if (enable_next && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'd1;
            end
            if ((cur_state == RUN) && (next_state == RUN) && !tc) begin
                div_cnt <= div_cnt + CW'(1);
            end else begin
                div_cnt <= '0;
            end
            // Lets the resumed run release the breakpoint instruction once.
            if (skip_set) begin
                skip <= 1'b1;
            end else if (instruction_pointer != bp_addr) begin
                skip <= 1'b0;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cpu_run_control.sv
// tb/tb_cpu_run_control.sv - randomized scoreboard bench for cpu_run_control
module tb_cpu_run_control;
    localparam int SLOW = 8;
    localparam int FAST = 2;

    typedef struct {
        int c;
        int n;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        btn_run = 1'b0;
    logic        btn_step = 1'b0;
    logic        turbo = 1'b0;
    logic        bp_enable = 1'b0;
    logic [7:0]  bp_addr = 8'd0;
    logic [7:0]  ip;
    logic        enable;
    logic [1:0]  state;
    logic [15:0] instr_count;

    logic        run1 = 1'b0;
    logic        zero1 = 1'b0;
    logic [7:0]  zero8 = 8'd0;
    logic        en1;
    logic [1:0]  st1;
    logic [15:0] cnt1;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    exp_t sb[$];
    exp_t e;

    cpu_run_control #(.SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
        .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step),
        .turbo(turbo), .bp_enable(bp_enable), .bp_addr(bp_addr),
        .instruction_pointer(ip), .enable(enable), .state(state),
        .instr_count(instr_count)
    );

    cpu_run_control #(.SLOW_DIV(1), .FAST_DIV(1)) dut1 (
        .clk(clk), .resetn(resetn), .btn_run(run1), .btn_step(zero1),
        .turbo(turbo), .bp_enable(zero1), .bp_addr(zero8),
        .instruction_pointer(zero8), .enable(en1), .state(st1),
        .instr_count(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CPU stand-in: IP advances once per released instruction.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) ip <= 8'd0;
        else if (enable) ip <= ip + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && enable === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_enable", 32'(enable), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.c);
                chk("strobe_count", instr_count, e.n);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_strobe(input int c);
        if (exp_cnt < 65535) exp_cnt++;
        sb.push_back('{c, exp_cnt});
    endtask

    task automatic press(input bit r, input bit s, output int p);
        p = cyc;
        if (r) btn_run = 1'b1;
        if (s) btn_step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    task automatic do_reset();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn  = 1'b1;
        exp_cnt = 0;
        sb.delete();
    endtask

    // Pause after n strobes; the pause pulse lands anywhere up to and including the next tc.
    task automatic stop_run(input int tc0, input int div, input int n);
        int tc_last, q, d;
        tc_last = tc0 + (n - 1) * div;
        q = $urandom_range(tc_last + div - 2, tc_last - 1);
        wait_until(q);
        chk("running", state, 1);
        press(1'b1, 1'b0, d);
        wait_until(q + 3);
        chk("halted", state, 0);
        wait_until(q + 3 + 2 * SLOW);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic step_seg();
        int p;
        press(1'b0, 1'b1, p);
        expect_strobe(p + 3);
        wait_until(p + 3);
        chk("step_state", state, 2);
        wait_until(p + 4);
        chk("step_done", state, 0);
        chk("step_count", instr_count, exp_cnt);
    endtask

    task automatic run_seg(input bit both, input bit fast, input int n);
        int p, div;
        turbo     = fast;
        bp_enable = 1'b0;
        bp_addr   = 8'($urandom);
        div       = fast ? FAST : SLOW;
        press(1'b1, both, p);
        for (int j = 0; j < n; j++) expect_strobe(p + 3 + div + j * div);
        stop_run(p + 2 + div, div, n);
    endtask

    task automatic turbo_seg();
        int p;
        turbo     = 1'b0;
        bp_enable = 1'b0;
        press(1'b1, 1'b0, p);
        for (int j = 0; j < 3; j++) expect_strobe(p + 9 + j * FAST);
        wait_until(p + 8);
        turbo = 1'b1;
        stop_run(p + 8, FAST, 3);
        turbo = 1'b0;
    endtask

    task automatic bp_seg(input int b_sel, input bit resume_run);
        int p, q, b, div, tbrk, m;
        do_reset();
        b         = (b_sel > 0) ? b_sel : int'($urandom_range(6, 2));
        turbo     = 1'($urandom_range(1, 0));
        div       = turbo ? FAST : SLOW;
        bp_enable = 1'b1;
        bp_addr   = 8'(b);
        press(1'b1, 1'b0, p);
        for (int j = 0; j < b; j++) expect_strobe(p + 3 + div + j * div);
        tbrk = p + 2 + div + b * div;
        wait_until(tbrk + 1);
        chk("break_state", state, 3);
        chk("break_count", instr_count, b);
        chk("break_ip", ip, b);
        wait_until(tbrk + 1 + int'($urandom_range(5, 1)));
        chk("break_hold", state, 3);
        if (resume_run) begin
            m = $urandom_range(3, 1);
            press(1'b1, 1'b0, q);
            for (int j = 0; j < m; j++) expect_strobe(q + 3 + div + j * div);
            stop_run(q + 2 + div, div, m);
            chk("resume_ip", ip, b + m);
        end else begin
            press(1'b0, 1'b1, q);
            expect_strobe(q + 3);
            wait_until(q + 3);
            chk("break_step", state, 2);
            wait_until(q + 4);
            chk("break_step_done", state, 0);
            chk("break_step_count", instr_count, b + 1);
        end
        bp_enable = 1'b0;
    endtask

    task automatic reset_seg();
        int p, div, n, tcn;
        turbo     = 1'($urandom_range(1, 0));
        div       = turbo ? FAST : SLOW;
        bp_enable = 1'b0;
        n = $urandom_range(3, 1);
        press(1'b1, 1'b0, p);
        for (int j = 0; j < n; j++) expect_strobe(p + 3 + div + j * div);
        tcn = p + 2 + div + n * div;
        wait_until(tcn - 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_enable", enable, 0);
        chk("rst_state", state, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_sb", sb.size(), 0);
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        wait_until(cyc + 2 * SLOW);
        chk("rst_after", state, 0);
    endtask

    task automatic sat_seg();
        int p;
        p    = cyc;
        run1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run1 = 1'b0;
        wait_until(p + 3);
        chk("sat_run", st1, 1);
        chk("sat_pre_en", en1, 0);
        wait_until(p + 4);
        chk("sat_first_en", en1, 1);
        chk("sat_first_cnt", cnt1, 1);
        wait_until(p + 4 + 65533);
        chk("sat_fffe", cnt1, 16'hFFFE);
        wait_until(p + 4 + 65534);
        chk("sat_ffff", cnt1, 16'hFFFF);
        wait_until(p + 4 + 65600);
        chk("sat_hold", cnt1, 16'hFFFF);
        chk("sat_en_cont", en1, 1);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_enable", enable, 0);
        chk("reset_state", state, 0);
        chk("reset_count", instr_count, 0);
        chk("reset_en1", en1, 0);
        chk("reset_cnt1", cnt1, 0);
        resetn = 1'b1;
        @(negedge clk);
        repeat (3) step_seg();
        run_seg(1'b0, 1'b0, 5);
        repeat (3) run_seg(1'b0, 1'($urandom_range(1, 0)), int'($urandom_range(5, 1)));
        turbo_seg();
        run_seg(1'b1, 1'b0, 2);
        run_seg(1'b1, 1'b1, 3);
        bp_seg(3, 1'b1);
        repeat (3) bp_seg(0, 1'($urandom_range(1, 0)));
        repeat (2) reset_seg();
        sat_seg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
